// File: rtl/free_list.sv
// Physical-register free list for rename: hands out free tags, takes back released tags,
// and rolls speculative allocations back to the committed head on flush. Optional FREE_LIST_BYPASS_EN.
module free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = $clog2(PHYS_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             commit_alloc,
  input  logic             rel_valid,
  input  logic [TAG_W-1:0] rel_tag,
  output logic [TAG_W:0]   free_count,
  output logic             empty,
  output logic             overflow
);

  localparam int PW = TAG_W + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0] OCC_FULL  = PW'(PHYS_REGS);
  localparam logic [PW-1:0] TAIL_INIT = PW'(PHYS_REGS - ARCH_REGS);

  logic [TAG_W-1:0] r_entry [PHYS_REGS];
  logic [PW-1:0]    r_spec_head;
  logic [PW-1:0]    r_commit_head;
  logic [PW-1:0]    r_tail;
  logic             r_overflow;

  logic [PW-1:0]    w_free;
  logic             w_rel_drop;
  logic             w_rel_write;
  logic             w_bypass;
  logic             w_gnt;
  logic [TAG_W-1:0] w_tag;
  logic [PW-1:0]    w_commit_next;

  // Grant, release-acceptance and free-count decode from the registered pointers
  always_comb begin
    w_free        = r_tail - r_spec_head;
    w_rel_drop    = rel_valid && ((r_tail - r_commit_head) == OCC_FULL);
    w_rel_write   = rel_valid && !w_rel_drop;
    w_commit_next = r_commit_head + (commit_alloc ? PTR_ONE : PTR_ZERO);
    w_bypass      = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    // A dropped release never reaches storage, so it cannot be forwarded either
    w_bypass = (w_free == PTR_ZERO) && w_rel_write && alloc_req && !stall && !flush;
`endif
    if (w_bypass) begin
      w_gnt = 1'b1;
      w_tag = rel_tag;
    end else begin
      w_gnt = alloc_req && (w_free != PTR_ZERO) && !stall && !flush;
      w_tag = r_entry[r_spec_head[TAG_W-1:0]];
    end
  end

  assign alloc_gnt  = w_gnt;
  assign alloc_tag  = w_tag;
  assign free_count = w_free;
  assign empty      = (w_free == PTR_ZERO);
  assign overflow   = r_overflow;

  // Tag storage: reset maps the non-architectural tags into the first slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        r_entry[i] <= TAG_W'(i + ARCH_REGS);
      end
    end else if (w_rel_write) begin
      r_entry[r_tail[TAG_W-1:0]] <= rel_tag;
    end
  end

  // Pointer and sticky overflow update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_head   <= PTR_ZERO;
      r_commit_head <= PTR_ZERO;
      r_tail        <= TAIL_INIT;
      r_overflow    <= 1'b0;
    end else begin
      r_commit_head <= w_commit_next;
      if (w_rel_write) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_rel_drop) begin
        r_overflow <= 1'b1;
      end
      // Flush wins over grant; the flush cycle never grants anyway
      if (flush) begin
        r_spec_head <= w_commit_next;
      end else if (w_gnt) begin
        r_spec_head <= r_spec_head + PTR_ONE;
      end
    end
  end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage, directly upstream of the active list. It hands out free physical tags to renaming instructions and takes back tags that commit releases. A committed head pointer lets it roll speculative allocations back in one cycle on a pipeline flush, so the active list and the free list always agree on which tags are live.

## Interface
- PHYS_REGS, 64, number of physical registers; power of two.
- ARCH_REGS, 32, number of architectural registers; tags 0..ARCH_REGS-1 are mapped at reset.
- TAG_W, $clog2(PHYS_REGS), tag width.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hazard-control stall; blocks allocation only
- flush  in  1  hazard-control flush; discards speculative allocations
- alloc_req  in  1  rename stage requests one tag this cycle
- alloc_gnt  out  1  tag granted this cycle (combinational)
- alloc_tag  out  TAG_W  granted tag, valid when alloc_gnt
- commit_alloc  in  1  the committing active-list entry allocated a tag
- rel_valid  in  1  commit releases a previously mapped tag
- rel_tag  in  TAG_W  tag being released
- free_count  out  TAG_W+1  speculatively free tags (tail - spec_head)
- empty  out  1  free_count == 0
- overflow  out  1  sticky; release attempted while storage held PHYS_REGS tags

## Operation
- Storage: circular array of PHYS_REGS entries of TAG_W bits. Pointers spec_head, commit_head and tail are TAG_W+1 bits wide. The extra MSB distinguishes full from empty; the index is the low TAG_W bits.
- Reset: entries 0..PHYS_REGS-ARCH_REGS-1 hold tags ARCH_REGS..PHYS_REGS-1 in order. spec_head = commit_head = 0. tail = PHYS_REGS-ARCH_REGS.
- Allocate: alloc_gnt = alloc_req & !empty & !stall & !flush. alloc_tag = entry[spec_head]. A grant increments spec_head at the next edge.
- Commit: commit_alloc increments commit_head. It is independent of stall and flush.
- Release: rel_valid writes rel_tag to entry[tail] and increments tail. It is independent of stall and flush. If (tail - commit_head) == PHYS_REGS, the write is dropped and overflow is set; overflow clears only on reset.
- Flush: spec_head <= commit_head + commit_alloc. The flush cycle grants nothing.
- Simultaneous release and allocate: both occur. A release is never visible to an allocate in the same cycle unless the bypass below is compiled in.
- Pointer wrap: all pointers wrap modulo 2*PHYS_REGS naturally.
- No FSM. State is three pointers, storage and the overflow flag.

## Timing
- Allocation latency 0: tag and grant are available in the request cycle. Pointer updates land at posedge clk.
- A released tag can be allocated 1 cycle after rel_valid.
- free_count and empty are combinational from registered pointers and reflect the state after the last edge.
- Reset values: alloc_gnt 0, alloc_tag = ARCH_REGS (entry 0), free_count = PHYS_REGS-ARCH_REGS, empty 0, overflow 0.
- Asynchronous reset mid-operation restores the reset state immediately. In-flight grants are lost; upstream must also be in reset.

## Configuration
- FREE_LIST_BYPASS_EN defined: when empty, rel_valid and alloc_req are high, and there is no stall or flush, alloc_gnt = 1 and alloc_tag = rel_tag. In that cycle tail and spec_head both increment, so the entry is written and consumed.
- FREE_LIST_BYPASS_EN undefined: empty always blocks allocation. A release made while empty is allocatable from the next cycle.

## Test plan
- Reset, then alloc_req held for 32 cycles -> tags 32..63 granted in order, empty = 1 after the 32nd grant, 33rd request gets alloc_gnt 0.
- After 32 grants, release tag 5 -> next cycle alloc_gnt 1 with alloc_tag 5; free_count goes 0 -> 1 -> 0.
- Grant 4 tags (32..35), commit_alloc once, then flush -> spec_head rolls back; next grant returns tag 33, free_count = 31.
- flush and commit_alloc in the same cycle after grants 32..34 -> next grant returns tag 33.
- Release 33 tags with no commits from reset (tail - commit_head hits 64) -> the 33rd release is dropped, overflow = 1 and remains 1 until rst_n low.
- Empty list, same-cycle rel_valid (tag 7) and alloc_req -> with FREE_LIST_BYPASS_EN, grant of tag 7 that cycle; without it, no grant, then tag 7 granted the next cycle.
